stepper_phase_driver: RTL and testbench
=======================================

Name: stepper_phase_driver

Overview:
Output stage directly downstream of the datapath. It consumes the 4-bit coil pattern from the datapath's stepper signal output (the registered stepper ROM) and drives the motor coil pins. The driver inserts all-off dead time between pattern changes, enforces a minimum step interval, drops to PWM hold current after inactivity, and blocks illegal coil patterns with a sticky fault.

Parameters:
DEAD_CYCLES, 4, cycles all coils are held off between two patterns (must be >= 1)
MIN_STEP_CYCLES, 50, minimum cycles a pattern is driven before the next change is accepted
HOLD_TIMEOUT, 1000, cycles without a pattern change before entering hold (must be > MIN_STEP_CYCLES)
PWM_PERIOD, 16, hold-mode PWM period in cycles
HOLD_DUTY, 4, on-cycles per PWM period in hold (must be < PWM_PERIOD)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
enable  in  1  driver enable; low forces coils off
phase_in  in  4  requested coil pattern from datapath stepper_signals; bits 0/2 and 1/3 are opposite coils
coils  out  4  registered coil drive
busy  out  1  dead time in progress or change pending on MIN_STEP_CYCLES
holding  out  1  hold (PWM) mode active
fault  out  1  sticky illegal-pattern flag

Behaviour:
- One clock and one reset: synchronous, active-high. On reset: coils=0, busy=0, holding=0, fault=0, state=DISABLED, phase_q=0, active=0, target=0, all counters=0.
- phase_in is registered into phase_q every cycle. The FSM acts on phase_q. All outputs are registered.
- Legal pattern: popcount<=2, and not (b0&b2), and not (b1&b3). 0000 is legal.
- States: DISABLED, DEAD, DRIVE, HOLD, FAULT.
- DISABLED: coils=0.
  - enable=1: target<=phase_q; go to DEAD, or to FAULT if phase_q is illegal.
- DEAD: coils=0. dead_cnt counts up.
  - Each cycle, target<=phase_q (latest wins).
  - When dead_cnt reaches DEAD_CYCLES: active<=target, coils<=target, step_timer=0, idle_cnt=0, go to DRIVE.
  - Timing: if phase_q first differs at edge E, coils are 0 for edges E+1..E+DEAD_CYCLES. The new pattern appears at edge E+DEAD_CYCLES+1.
- DRIVE: coils=active.
  - step_timer saturates at MIN_STEP_CYCLES. idle_cnt saturates at HOLD_TIMEOUT.
  - phase_q!=active and step_timer==MIN_STEP_CYCLES: go to DEAD.
  - phase_q!=active and timer not expired: pending (busy=1). Move to DEAD on the first cycle the timer expires, using the phase_q value at that time.
  - If phase_q returns to active before expiry, the pending change is cancelled and busy=0.
  - idle_cnt==HOLD_TIMEOUT with no pending change: go to HOLD.
- HOLD: holding=1. pwm_cnt wraps 0..PWM_PERIOD-1. coils=active when pwm_cnt<HOLD_DUTY, else 0.
  - phase_q!=active: go to DEAD immediately; holding=0 on the next cycle.
- FAULT: coils=0, fault=1.
  - Exits only through enable=0 (to DISABLED, fault cleared) or reset.
- Illegal phase_q in DEAD, DRIVE or HOLD: go to FAULT next edge, coils=0 from that edge.
- busy=1 in DEAD, or in DRIVE with a pending change; otherwise 0.
- enable=0 in any state: DISABLED next edge, coils=0 from that edge. This has priority over fault detection, so a simultaneous illegal pattern sets no fault.
- Counter widths: $clog2(param+1), saturating, no wrap except pwm_cnt.

Decomposition:
- Package stepper_pkg holds:
  - state enum
  - COIL_W=4
  - function is_legal_pattern
- Sub-module hold_pwm: free-running counter with a duty compare, taking enable and returning pwm_on.

Test Plan:
All tests use DEAD_CYCLES=2, MIN_STEP_CYCLES=8, HOLD_TIMEOUT=20, PWM_PERIOD=4, HOLD_DUTY=1.
- Reset, then enable=1 with phase_in=0001: coils=0000 for 2 cycles, then 0001; busy=1 during the dead time.
- Step 0001→0011 after 10 cycles in DRIVE (phase_q updates at edge E): coils=0000 at E+1..E+2 and 0011 at E+3. Changing to 0010 at 3 cycles after apply holds busy=1 until step_timer=8, then dead time, then 0010.
- No change for 20 cycles in DRIVE: holding=1 and coils toggle 0011,0000,0000,0000 repeating. phase_in=0110 exits hold: holding=0, dead time, then 0110.
- phase_in=0101 while in DRIVE: coils=0000 and fault=1 from the next state edge. fault persists with legal input. enable=0 for one cycle clears fault and coils stay 0000.
- Simultaneous enable=0 and phase_in=1111: DISABLED, fault=0. Reset asserted mid-DEAD: all outputs 0 the next edge.

Source files
------------

// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper coil driver: state encoding, coil width
// and the legal-pattern check used by the FSM.
package stepper_pkg;

    localparam int COIL_W = 4;

    localparam logic [2:0] ST_DISABLED = 3'd0;
    localparam logic [2:0] ST_DEAD     = 3'd1;
    localparam logic [2:0] ST_DRIVE    = 3'd2;
    localparam logic [2:0] ST_HOLD     = 3'd3;
    localparam logic [2:0] ST_FAULT    = 3'd4;

    // Opposite coils (0/2, 1/3) must never be energised together.
    function automatic logic is_legal_pattern(input logic [COIL_W-1:0] p);
        logic [2:0] ones;
        ones = 3'(p[0]) + 3'(p[1]) + 3'(p[2]) + 3'(p[3]);
        return (ones <= 3'd2) && !(p[0] && p[2]) && !(p[1] && p[3]);
    endfunction

endpackage

// File: rtl/hold_pwm.sv
// Free-running hold-current PWM; pwm_on reflects the count being loaded this
// cycle so it lines up with the registered coil outputs.
module hold_pwm #(
    parameter int PWM_PERIOD = 16,
    parameter int HOLD_DUTY  = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic pwm_on
);
    localparam int CW = $clog2(PWM_PERIOD + 1);

    logic [CW-1:0] pwm_cnt;
    logic [CW-1:0] cnt_next;

    always_comb begin
        cnt_next = '0;
        if (enable && (pwm_cnt != CW'(PWM_PERIOD - 1)))
            cnt_next = pwm_cnt + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) pwm_cnt <= '0;
        else       pwm_cnt <= cnt_next;
    end

    assign pwm_on = (cnt_next < CW'(HOLD_DUTY));

endmodule

// File: rtl/stepper_phase_driver.sv
// Coil output stage: dead time between patterns, minimum step interval,
// PWM hold after inactivity, sticky fault on illegal coil patterns.
//
//   state    | meaning
//   DISABLED | enable low, coils off
//   DEAD     | all coils off between two patterns
//   DRIVE    | active pattern driven at full current
//   HOLD     | active pattern chopped by the hold PWM
//   FAULT    | illegal pattern seen, coils off until enable drops
module stepper_phase_driver
    import stepper_pkg::*;
#(
    parameter int DEAD_CYCLES     = 4,
    parameter int MIN_STEP_CYCLES = 50,
    parameter int HOLD_TIMEOUT    = 1000,
    parameter int PWM_PERIOD      = 16,
    parameter int HOLD_DUTY       = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [COIL_W-1:0] phase_in,
    output logic [COIL_W-1:0] coils,
    output logic              busy,
    output logic              holding,
    output logic              fault
);
    localparam int DW = $clog2(DEAD_CYCLES + 1);
    localparam int SW = $clog2(MIN_STEP_CYCLES + 1);
    localparam int IW = $clog2(HOLD_TIMEOUT + 1);
    localparam logic [DW-1:0] DEAD_MAX = DW'(DEAD_CYCLES);
    localparam logic [SW-1:0] STEP_MAX = SW'(MIN_STEP_CYCLES);
    localparam logic [IW-1:0] IDLE_MAX = IW'(HOLD_TIMEOUT);

    logic [2:0]        state, state_d;
    logic [COIL_W-1:0] phase_q, active, active_d, target, target_d, coils_d;
    logic [DW-1:0]     dead_cnt, dead_d;
    logic [SW-1:0]     step_timer, step_d;
    logic [IW-1:0]     idle_cnt, idle_d;
    logic              pending, legal, changed, pwm_on;

    hold_pwm #(
        .PWM_PERIOD (PWM_PERIOD),
        .HOLD_DUTY  (HOLD_DUTY)
    ) u_hold_pwm (
        .clk    (clk),
        .reset  (reset),
        .enable (state == ST_HOLD),
        .pwm_on (pwm_on)
    );

    assign legal   = is_legal_pattern(phase_q);
    assign changed = (phase_q != active);

    always_comb begin
        state_d  = state;
        active_d = active;
        target_d = target;
        dead_d   = dead_cnt;
        step_d   = step_timer;
        idle_d   = idle_cnt;
        coils_d  = '0;
        pending  = 1'b0;
        // Disable outranks fault detection so a dropping enable never latches a fault.
        if (!enable) begin
            state_d = ST_DISABLED;
        end else begin
            case (state)
                ST_DISABLED: begin
                    target_d = phase_q;
                    dead_d   = DW'(1);
                    state_d  = legal ? ST_DEAD : ST_FAULT;
                end
                ST_DEAD: begin
                    target_d = phase_q;
                    if (!legal) begin
                        state_d = ST_FAULT;
                    end else if (dead_cnt == DEAD_MAX) begin
                        state_d  = ST_DRIVE;
                        active_d = target;
                        coils_d  = target;
                        step_d   = '0;
                        idle_d   = '0;
                    end else begin
                        dead_d = dead_cnt + DW'(1);
                    end
                end
                ST_DRIVE: begin
                    step_d = (step_timer == STEP_MAX) ? step_timer : step_timer + SW'(1);
                    idle_d = (idle_cnt == IDLE_MAX) ? idle_cnt : idle_cnt + IW'(1);
                    if (!legal) begin
                        state_d = ST_FAULT;
                    end else if (changed && (step_timer == STEP_MAX)) begin
                        state_d  = ST_DEAD;
                        target_d = phase_q;
                        dead_d   = DW'(1);
                    end else if (changed) begin
                        pending = 1'b1;
                        coils_d = active;
                    end else if (idle_cnt == IDLE_MAX) begin
                        state_d = ST_HOLD;
                        coils_d = pwm_on ? active : '0;
                    end else begin
                        coils_d = active;
                    end
                end
                ST_HOLD: begin
                    if (!legal) begin
                        state_d = ST_FAULT;
                    end else if (changed) begin
                        state_d  = ST_DEAD;
                        target_d = phase_q;
                        dead_d   = DW'(1);
                    end else begin
                        coils_d = pwm_on ? active : '0;
                    end
                end
                ST_FAULT: state_d = ST_FAULT;
                default:  state_d = ST_DISABLED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_DISABLED;
            phase_q    <= '0;
            active     <= '0;
            target     <= '0;
            dead_cnt   <= '0;
            step_timer <= '0;
            idle_cnt   <= '0;
            coils      <= '0;
            busy       <= 1'b0;
            holding    <= 1'b0;
            fault      <= 1'b0;
        end else begin
            state      <= state_d;
            phase_q    <= phase_in;
            active     <= active_d;
            target     <= target_d;
            dead_cnt   <= dead_d;
            step_timer <= step_d;
            idle_cnt   <= idle_d;
            coils      <= coils_d;
            busy       <= (state_d == ST_DEAD) || pending;
            holding    <= (state_d == ST_HOLD);
            fault      <= (state_d == ST_FAULT);
        end
    end

endmodule

// File: tb/tb_stepper_phase_driver.sv
// Directed bench for stepper_phase_driver: a vector table for bring-up, stepping,
// pending/cancel and hold, then hand sequences for fault, priority and reset.
module tb_stepper_phase_driver;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [3:0] phase_in = 4'b0000;
    logic [3:0] coils;
    logic       busy, holding, fault;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic       rst;
        logic       en;
        logic [3:0] ph;
        logic [3:0] coils;
        logic       busy;
        logic       holding;
        logic       fault;
        string      name;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    stepper_phase_driver #(
        .DEAD_CYCLES     (2),
        .MIN_STEP_CYCLES (8),
        .HOLD_TIMEOUT    (20),
        .PWM_PERIOD      (4),
        .HOLD_DUTY       (1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .phase_in (phase_in),
        .coils    (coils),
        .busy     (busy),
        .holding  (holding),
        .fault    (fault)
    );

    function automatic vec_t mk(input logic rst, input logic en, input logic [3:0] ph,
                                input logic [3:0] c, input logic b, input logic h,
                                input logic f, input string name);
        vec_t v;
        v.rst = rst; v.en = en; v.ph = ph;
        v.coils = c; v.busy = b; v.holding = h; v.fault = f; v.name = name;
        return v;
    endfunction

    task automatic add(input logic rst, input logic en, input logic [3:0] ph,
                       input logic [3:0] c, input logic b, input logic h,
                       input logic f, input string name, input int n);
        for (int i = 0; i < n; i++) vecs.push_back(mk(rst, en, ph, c, b, h, f, name));
    endtask

    // Inputs are applied just after an edge; outputs are sampled 1ns after the next one.
    task automatic run(input vec_t v);
        reset    = v.rst;
        enable   = v.en;
        phase_in = v.ph;
        @(posedge clk);
        #1;
        checks++;
        if ({coils, busy, holding, fault} === {v.coils, v.busy, v.holding, v.fault})
            passed++;
        else
            $display("FAIL %s @%0t: got coils=%b busy=%b holding=%b fault=%b, expected coils=%b busy=%b holding=%b fault=%b",
                     v.name, $time, coils, busy, holding, fault, v.coils, v.busy, v.holding, v.fault);
    endtask

    initial begin
        //  rst en  phase    coils   b  h  f  name               count
        add(1, 0, 4'b0000, 4'b0000, 0, 0, 0, "reset",            1);
        add(0, 1, 4'b0001, 4'b0000, 1, 0, 0, "bringup_dead",     2);
        add(0, 1, 4'b0001, 4'b0001, 0, 0, 0, "drive_0001",       10);
        add(0, 1, 4'b0011, 4'b0001, 0, 0, 0, "step_req",         1);
        add(0, 1, 4'b0011, 4'b0000, 1, 0, 0, "step_dead",        2);
        add(0, 1, 4'b0011, 4'b0011, 0, 0, 0, "drive_0011",       3);
        add(0, 1, 4'b0010, 4'b0011, 0, 0, 0, "early_req",        1);
        add(0, 1, 4'b0010, 4'b0011, 1, 0, 0, "pending",          5);
        add(0, 1, 4'b0010, 4'b0000, 1, 0, 0, "pending_dead",     2);
        add(0, 1, 4'b0010, 4'b0010, 0, 0, 0, "drive_0010",       1);
        add(0, 1, 4'b0011, 4'b0010, 0, 0, 0, "cancel_req",       1);
        add(0, 1, 4'b0010, 4'b0010, 1, 0, 0, "cancel_pending",   1);
        add(0, 1, 4'b0010, 4'b0010, 0, 0, 0, "cancelled",        1);
        add(0, 1, 4'b0010, 4'b0010, 0, 0, 0, "drive_0010_b",     5);
        add(0, 1, 4'b0011, 4'b0010, 0, 0, 0, "restep_req",       1);
        add(0, 1, 4'b0011, 4'b0000, 1, 0, 0, "restep_dead",      2);
        add(0, 1, 4'b0011, 4'b0011, 0, 0, 0, "drive_0011_b",     1);
        add(0, 1, 4'b0011, 4'b0011, 0, 0, 0, "pre_hold",         20);
        add(0, 1, 4'b0011, 4'b0011, 0, 1, 0, "hold_on",          1);
        add(0, 1, 4'b0011, 4'b0000, 0, 1, 0, "hold_off",         3);
        add(0, 1, 4'b0011, 4'b0011, 0, 1, 0, "hold_on_2",        1);
        add(0, 1, 4'b0011, 4'b0000, 0, 1, 0, "hold_off_2",       1);
        add(0, 1, 4'b0110, 4'b0000, 0, 1, 0, "hold_exit_req",    1);
        add(0, 1, 4'b0110, 4'b0000, 1, 0, 0, "hold_exit_dead",   2);
        add(0, 1, 4'b0110, 4'b0110, 0, 0, 0, "drive_0110",       1);

        foreach (vecs[i]) run(vecs[i]);

        // Illegal pattern in DRIVE, sticky fault, clear through enable.
        run(mk(0, 1, 4'b0101, 4'b0110, 0, 0, 0, "illegal_req"));
        run(mk(0, 1, 4'b0110, 4'b0000, 0, 0, 1, "fault_set"));
        for (int i = 0; i < 3; i++)
            run(mk(0, 1, 4'b0110, 4'b0000, 0, 0, 1, "fault_sticky"));
        run(mk(0, 0, 4'b0110, 4'b0000, 0, 0, 0, "fault_clear"));
        run(mk(0, 1, 4'b0110, 4'b0000, 1, 0, 0, "reenable_dead"));
        run(mk(0, 1, 4'b0110, 4'b0000, 1, 0, 0, "reenable_dead"));
        run(mk(0, 1, 4'b0110, 4'b0110, 0, 0, 0, "reenable_drive"));

        // Illegal pattern reaches the FSM on the same edge enable drops: no fault.
        run(mk(0, 1, 4'b1111, 4'b0110, 0, 0, 0, "bad_req"));
        run(mk(0, 0, 4'b1111, 4'b0000, 0, 0, 0, "disable_wins"));
        run(mk(0, 0, 4'b1111, 4'b0000, 0, 0, 0, "disabled_stays"));
        run(mk(0, 1, 4'b1111, 4'b0000, 0, 0, 1, "enable_on_illegal"));

        // Reset in the middle of dead time.
        run(mk(0, 0, 4'b0001, 4'b0000, 0, 0, 0, "disable_again"));
        run(mk(0, 1, 4'b0001, 4'b0000, 1, 0, 0, "dead_before_reset"));
        run(mk(1, 1, 4'b0001, 4'b0000, 0, 0, 0, "reset_mid_dead"));
        run(mk(0, 0, 4'b0000, 4'b0000, 0, 0, 0, "after_reset"));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
